// File: rtl/serial_add_sched_pkg.sv
// Shared types for the bit-serial add scheduler: FSM states, requester count and ID type.
`timescale 1ns/1ps
package serial_add_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int N_REQ = 2;

    typedef logic [0:0] req_id_t;

endpackage

// File: rtl/serial_add_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter. It issues a one-hot grant and remembers the last winner.
`timescale 1ns/1ps
module rr_arbiter_2
    import serial_add_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    logic last_grant;

    // On a tie, grant goes to the requester that did not win last time.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (|grant)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// Two requesters share one bit-serial full adder. Operands stream through LSB-first and
// the block returns a (W+1)-bit sum tagged with the ID of the requester that sent them.
`timescale 1ns/1ps
module serial_add_scheduler
    import serial_add_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         valid0,
    output logic         ready0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         valid1,
    output logic         ready1,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   res_sum,
    output logic         res_id
);

    localparam int CW = $clog2(W + 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     a_sh, b_sh, sum_sh, sum_nx;
    logic             carry, bit_s, carry_nx;
    req_id_t          id;
    logic [N_REQ-1:0] grant;
    logic             accept;
    logic [W-1:0]     a_g, b_g;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({valid1, valid0}),
        .advance (accept),
        .grant   (grant)
    );

    assign accept = (state == IDLE) && (valid0 || valid1);
    assign a_g    = grant[1] ? a1 : a0;
    assign b_g    = grant[1] ? b1 : b0;

    // Ready is gated with rst_n so that no requester sees an accept while reset is held.
    assign ready0 = rst_n && (state == IDLE) && grant[0];
    assign ready1 = rst_n && (state == IDLE) && grant[1];

    assign bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    always_comb begin
        sum_nx        = sum_sh >> 1;
        sum_nx[W-1]   = bit_s;
    end

    assign res_valid = (state == DONE);
    assign res_sum   = {carry, sum_sh};
    assign res_id    = id[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (cnt == CW'(W - 1)) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Carry is left alone in DONE because it forms the top bit of the returned sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a_g;
                        b_sh  <= b_g;
                        carry <= 1'b0;
                        cnt   <= '0;
                        id    <= req_id_t'(grant[1]);
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nx;
                    carry  <= carry_nx;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Testbench for serial_add_scheduler. The reference model predicts the arbitration
// winner, the arithmetic sum and the latency; a second instance covers W=1.
`timescale 1ns/1ps
module tb_serial_add_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a0, b0, a1, b1;
    logic         valid0, valid1, ready0, ready1;
    logic         res_valid, res_ready, res_id;
    logic [W:0]   res_sum;

    logic [0:0]   w1_a0, w1_b0, w1_a1, w1_b1;
    logic         w1_valid0, w1_valid1, w1_ready0, w1_ready1;
    logic         w1_res_valid, w1_res_ready, w1_res_id;
    logic [1:0]   w1_res_sum;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_res_cyc = -1;
    logic last_grant_model = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a0(a0), .b0(b0), .valid0(valid0), .ready0(ready0),
        .a1(a1), .b1(b1), .valid1(valid1), .ready1(ready1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id)
    );

    serial_add_scheduler #(.W(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .a0(w1_a0), .b0(w1_b0), .valid0(w1_valid0), .ready0(w1_ready0),
        .a1(w1_a1), .b1(w1_b1), .valid1(w1_valid1), .ready1(w1_ready1),
        .res_valid(w1_res_valid), .res_ready(w1_res_ready),
        .res_sum(w1_res_sum), .res_id(w1_res_id)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Drives one operation and follows it through to the result handshake.
    // Entry and exit happen just after a posedge, with the DUT in IDLE.
    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [W-1:0] x0, input logic [W-1:0] y0,
                                 input logic [W-1:0] x1, input logic [W-1:0] y1,
                                 input int stall, input bit hold);
        logic       g;
        logic [W:0] exp_sum;
        int         acc_cyc;
        int         lat;
        if (v0 && !v1)      g = 1'b0;
        else if (v1 && !v0) g = 1'b1;
        else                g = ~last_grant_model;
        exp_sum = g ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});

        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        valid0 = v0; valid1 = v1;
        res_ready = (stall == 0);

        @(negedge clk);
        checkOutput("ready0_idle", ready0, !g);
        checkOutput("ready1_idle", ready1, g);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        last_grant_model = g;
        if (!hold) begin
            valid0 = 1'b0;
            valid1 = 1'b0;
        end

        lat = -1;
        for (int j = 1; j <= W + 4; j++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
            checkOutput("ready_busy", {ready0, ready1}, 0);
        end
        checkOutput("latency", lat, W);
        last_res_cyc = cyc;
        checkOutput("res_sum", res_sum, exp_sum);
        checkOutput("res_id", res_id, g);
        checkOutput("ready_done", {ready0, ready1}, 0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", res_valid, 1);
            checkOutput("stall_sum", res_sum, exp_sum);
            checkOutput("stall_id", res_id, g);
            checkOutput("stall_ready", {ready0, ready1}, 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("res_valid_clr", res_valid, 0);
    endtask

    task automatic runW1(input logic x, input logic y);
        logic [1:0] exp_sum;
        exp_sum = {1'b0, x} + {1'b0, y};
        w1_a0 = x; w1_b0 = y; w1_valid0 = 1'b1; w1_res_ready = 1'b1;
        @(negedge clk);
        checkOutput("w1_ready0", w1_ready0, 1);
        @(posedge clk);
        #1;
        w1_valid0 = 1'b0;
        @(negedge clk);
        checkOutput("w1_run_valid", w1_res_valid, 0);
        @(negedge clk);
        checkOutput("w1_res_valid", w1_res_valid, 1);
        checkOutput("w1_res_sum", w1_res_sum, exp_sum);
        checkOutput("w1_res_id", w1_res_id, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_cyc;
        rst_n = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        valid0 = 1'b1; valid1 = 1'b0; res_ready = 1'b1;
        w1_a0 = '0; w1_b0 = '0; w1_a1 = '0; w1_b1 = '0;
        w1_valid0 = 1'b0; w1_valid1 = 1'b0; w1_res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_sum", res_sum, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_ready", {ready0, ready1}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        valid0 = 1'b0;
        last_grant_model = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single requester and overflow");
        applyStimulus(1, 0, 8'h0F, 8'h01, 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 0);
        applyStimulus(0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0);

        $display("[TB] simultaneous requests after reset");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_grant_model = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 8'd3, 8'd4, 8'd5, 8'd6, 0, 1);
        first_cyc = last_res_cyc;
        applyStimulus(1, 1, 8'd3, 8'd4, 8'd5, 8'd6, 0, 1);
        checkOutput("rr_spacing", last_res_cyc - first_cyc, W + 2);
        applyStimulus(1, 1, 8'd3, 8'd4, 8'd5, 8'd6, 0, 0);

        $display("[TB] backpressure");
        applyStimulus(1, 0, 8'h21, 8'h42, 8'h00, 8'h00, 5, 0);

        $display("[TB] reset during RUN");
        valid0 = 1'b1; valid1 = 1'b0; a0 = 8'hAA; b0 = 8'h55; res_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", res_valid, 0);
        checkOutput("mid_rst_ready", {ready0, ready1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid0 = 1'b0;
        last_grant_model = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 30; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            applyStimulus(pat[0], pat[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                          $urandom_range(0, 2), 0);
        end

        $display("[TB] W=1 instance");
        runW1(1'b1, 1'b1);
        runW1(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
